// File: rtl/itag_fill.sv
// I-cache tag/data write-side controller: invalidate-then-fill on miss,
// critical-word-first line fetch, and full-cache invalidate sweep.
module itag_fill #(
    parameter int NL  = 128,
    parameter int LSS = 7,
    parameter int LSH = LSS + 4,
    parameter int PSL = LSH + 1,
    parameter int TS  = 2 + (32 - PSL)
) (
    input  logic            nGCLK,
    input  logic            reset,
    input  logic            miss,
    input  logic [31:0]     miss_addr,
    input  logic            inval_req,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    input  logic            mem_ack,
    input  logic [31:0]     mem_data,
    output logic            dram_wr,
    output logic [LSS+2:0]  dram_sel,
    output logic [31:0]     dram_data,
    output logic            tag_wr_ena,
    output logic [LSS-1:0]  tag_wr_sel,
    output logic [TS-1:0]   tag_wr_data,
    output logic            fill_done,
    output logic            inval_done,
    output logic            busy
);

    localparam int TW = 32 - PSL;
    localparam logic [LSS-1:0] LAST_LINE = LSS'(NL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FINV  = 3'd1,
        S_FILL  = 3'd2,
        S_FTAG  = 3'd3,
        S_GAP   = 3'd4,
        S_SWEEP = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_pend;
    logic [LSS-1:0]  r_line;
    logic [2:0]      r_word0;
    logic [TW-1:0]   r_tag;
    logic [2:0]      r_beat;
    logic [LSS-1:0]  r_count;

    logic            w_pend_any;
    logic            w_start_fill;
    logic            w_sweep_last;
    logic [2:0]      w_word;
    logic            w_unused_bits;

    assign w_pend_any    = r_pend | inval_req;
    assign w_start_fill  = (r_state == S_IDLE) && !w_pend_any && miss;
    assign w_sweep_last  = (r_state == S_SWEEP) && (r_count == LAST_LINE);
    assign w_word        = r_word0 + r_beat;
    assign w_unused_bits = ^miss_addr[1:0];

    always_ff @(posedge nGCLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pend_any)
                    w_state_next = S_SWEEP;
                else if (miss)
                    w_state_next = S_FINV;
            end
            S_FINV:  w_state_next = S_FILL;
            S_FILL: begin
                if (mem_ack && (r_beat == 3'd7))
                    w_state_next = S_FTAG;
            end
            S_FTAG:  w_state_next = S_GAP;
            S_GAP:   w_state_next = S_IDLE;
            S_SWEEP: begin
                if (r_count == LAST_LINE)
                    w_state_next = S_GAP;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pending invalidate survives the final sweep cycle if re-requested there.
    always_ff @(posedge nGCLK or posedge reset) begin
        if (reset) begin
            r_pend  <= 1'b0;
            r_line  <= '0;
            r_word0 <= '0;
            r_tag   <= '0;
            r_beat  <= '0;
            r_count <= '0;
        end else begin
            if (w_sweep_last)
                r_pend <= inval_req;
            else if (inval_req)
                r_pend <= 1'b1;

            if (w_start_fill) begin
                r_line  <= miss_addr[LSH:5];
                r_word0 <= miss_addr[4:2];
                r_tag   <= miss_addr[31:PSL];
                r_beat  <= '0;
            end else if ((r_state == S_FILL) && mem_ack) begin
                r_beat  <= r_beat + 3'd1;
            end

            if (r_state == S_SWEEP)
                r_count <= r_count + LSS'(1);
            else
                r_count <= '0;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = '0;
        dram_wr     = 1'b0;
        dram_sel    = '0;
        dram_data   = '0;
        tag_wr_ena  = 1'b0;
        tag_wr_sel  = '0;
        tag_wr_data = '0;
        fill_done   = 1'b0;
        inval_done  = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_FINV: begin
                tag_wr_ena  = 1'b1;
                tag_wr_sel  = r_line;
                tag_wr_data = {2'b00, r_tag};
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_line, w_word, 2'b00};
                if (mem_ack) begin
                    dram_wr   = 1'b1;
                    dram_sel  = {r_line, w_word};
                    dram_data = mem_data;
                end
            end
            S_FTAG: begin
                tag_wr_ena  = 1'b1;
                tag_wr_sel  = r_line;
                tag_wr_data = {2'b01, r_tag};
                fill_done   = 1'b1;
            end
            S_SWEEP: begin
                tag_wr_ena  = 1'b1;
                tag_wr_sel  = r_count;
                inval_done  = (r_count == LAST_LINE);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_itag_fill.sv
// Scoreboard bench for itag_fill: stimulus queues expected tag/data writes,
// a negedge monitor pops and compares whatever the DUT writes.
module tb_itag_fill;

    logic        nGCLK = 1'b0;
    logic        reset = 1'b1;
    logic        miss = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        inval_req = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data;
    logic        dram_wr;
    logic [9:0]  dram_sel;
    logic [31:0] dram_data;
    logic        tag_wr_ena;
    logic [6:0]  tag_wr_sel;
    logic [21:0] tag_wr_data;
    logic        fill_done;
    logic        inval_done;
    logic        busy;

    itag_fill dut (
        .nGCLK      (nGCLK),
        .reset      (reset),
        .miss       (miss),
        .miss_addr  (miss_addr),
        .inval_req  (inval_req),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .dram_wr    (dram_wr),
        .dram_sel   (dram_sel),
        .dram_data  (dram_data),
        .tag_wr_ena (tag_wr_ena),
        .tag_wr_sel (tag_wr_sel),
        .tag_wr_data(tag_wr_data),
        .fill_done  (fill_done),
        .inval_done (inval_done),
        .busy       (busy)
    );

    always #5 nGCLK = ~nGCLK;

    // Memory model: each word reads back a tag of its own address.
    assign mem_data = 32'hC0DE_0000 | {16'h0000, mem_addr[15:0]};

    typedef struct packed {
        logic [6:0]  sel;
        logic [21:0] data;
        logic        fd;
        logic        id;
    } tag_t;

    typedef struct packed {
        logic [9:0]  sel;
        logic [31:0] data;
        logic [31:0] addr;
    } dram_t;

    localparam logic [31:0] ADDR   = 32'h0001_2A74;
    localparam logic [6:0]  LINE   = 7'h53;
    localparam logic [21:0] TAGINV = 22'h000012;
    localparam logic [21:0] TAGVAL = 22'h100012;

    logic [31:0] exp_addr [8] = '{32'h00012A74, 32'h00012A78, 32'h00012A7C, 32'h00012A60,
                                  32'h00012A64, 32'h00012A68, 32'h00012A6C, 32'h00012A70};
    logic [2:0]  exp_word [8] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic        stall_pat [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    tag_t  tag_q [$];
    dram_t dram_q [$];
    tag_t  te;
    dram_t de;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    n_id = 0;

    always @(posedge nGCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge nGCLK) begin
        if (!reset) begin
            if (tag_wr_ena) begin
                if (tag_q.size() == 0) begin
                    chk("tag_wr_unexpected", 64'(tag_wr_ena), 64'd0);
                end else begin
                    te = tag_q.pop_front();
                    chk("tag_write", 64'({tag_wr_sel, tag_wr_data, fill_done, inval_done}), 64'(te));
                end
            end else if (fill_done || inval_done) begin
                chk("done_without_tag_wr", 64'({fill_done, inval_done}), 64'd0);
            end
            if (inval_done) n_id++;
            if (mem_req) begin
                if (dram_q.size() == 0) begin
                    chk("mem_req_unexpected", 64'(mem_req), 64'd0);
                end else begin
                    chk("mem_addr", 64'(mem_addr), 64'(dram_q[0].addr));
                    if (dram_wr) begin
                        de = dram_q.pop_front();
                        chk("dram_write", 64'({dram_sel, dram_data}), 64'({de.sel, de.data}));
                    end
                end
            end else if (dram_wr) begin
                chk("dram_wr_unexpected", 64'(dram_wr), 64'd0);
            end
        end
    end

    task automatic push_fill();
        dram_t d;
        tag_q.push_back('{sel: LINE, data: TAGINV, fd: 1'b0, id: 1'b0});
        for (int i = 0; i < 8; i++) begin
            d.sel  = {LINE, exp_word[i]};
            d.addr = exp_addr[i];
            d.data = 32'hC0DE_0000 | {16'h0000, exp_addr[i][15:0]};
            dram_q.push_back(d);
        end
        tag_q.push_back('{sel: LINE, data: TAGVAL, fd: 1'b1, id: 1'b0});
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 128; i++)
            tag_q.push_back('{sel: 7'(i), data: 22'h0, fd: 1'b0, id: (i == 127)});
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_mem"},   64'({mem_req, mem_addr}), 64'd0);
        chk({pfx, "_dram"},  64'({dram_wr, dram_sel, dram_data}), 64'd0);
        chk({pfx, "_tag"},   64'({tag_wr_ena, tag_wr_sel, tag_wr_data}), 64'd0);
        chk({pfx, "_flags"}, 64'({fill_done, inval_done, busy}), 64'd0);
    endtask

    task automatic check_queues(input string pfx);
        chk({pfx, "_tagq_left"},  64'(tag_q.size()), 64'd0);
        chk({pfx, "_dramq_left"}, 64'(dram_q.size()), 64'd0);
    endtask

    // Runs one miss on ADDR; lat is cycles from the miss-sampling edge to fill_done, inclusive.
    task automatic do_fill(input bit stall, input bit inv_mid, input bit inv_first, output int lat);
        int k;
        int c0;
        bit seen;
        k = 0;
        seen = 1'b0;
        lat = 0;
        @(posedge nGCLK); #1;
        miss = 1'b1;
        miss_addr = ADDR;
        inval_req = inv_first;
        c0 = cyc + 1;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(posedge nGCLK); #1;
            inval_req = 1'b0;
            if (mem_req) begin
                mem_ack = (stall && k < 12) ? stall_pat[k] : 1'b1;
                inval_req = inv_mid && (k == 2 || k == 5);
                k++;
            end else begin
                mem_ack = 1'b0;
            end
            if (fill_done) begin
                seen = 1'b1;
                lat = cyc - c0 + 1;
                miss = 1'b0;
                mem_ack = 1'b0;
            end
        end
        mem_ack = 1'b0;
        inval_req = 1'b0;
        miss = 1'b0;
        chk("fill_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_inval(output int c);
        bit seen;
        seen = 1'b0;
        c = 0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(posedge nGCLK); #1;
            if (inval_done) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        chk("inval_done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int lat2;
        int lat3;
        int c_start;
        int c_done;
        int id0;

        #1;
        check_zero("init_rst");
        @(posedge nGCLK); #1;
        reset = 1'b0;
        repeat (2) @(posedge nGCLK);

        // Plain fill, ack every cycle
        push_fill();
        do_fill(1'b0, 1'b0, 1'b0, lat2);
        chk("latency_nostall", 64'(lat2), 64'd10);
        @(posedge nGCLK); #1;
        chk("gap_busy", 64'({busy, fill_done}), 64'b10);
        @(posedge nGCLK); #1;
        chk("idle_after_gap", 64'(busy), 64'd0);
        check_queues("fill");

        // Two 2-cycle stalls before beats 0 and 4
        push_fill();
        do_fill(1'b1, 1'b0, 1'b0, lat3);
        chk("latency_stall", 64'(lat3), 64'(lat2 + 4));
        repeat (3) @(posedge nGCLK);
        check_queues("stall");

        // Invalidate sweep from IDLE
        id0 = n_id;
        @(posedge nGCLK); #1;
        push_sweep();
        inval_req = 1'b1;
        c_start = cyc;
        @(posedge nGCLK); #1;
        inval_req = 1'b0;
        wait_inval(c_done);
        chk("sweep_len", 64'(c_done - c_start), 64'd128);
        @(posedge nGCLK); #1;
        chk("sweep_gap_busy", 64'(busy), 64'd1);
        @(posedge nGCLK); #1;
        chk("sweep_idle", 64'(busy), 64'd0);
        repeat (10) @(posedge nGCLK);
        chk("sweep_once", 64'(n_id - id0), 64'd1);
        check_queues("sweep");

        // Two inval pulses during a fill collapse to one sweep after the fill
        id0 = n_id;
        push_fill();
        push_sweep();
        do_fill(1'b0, 1'b1, 1'b0, lat2);
        wait_inval(c_done);
        repeat (12) @(posedge nGCLK);
        chk("collide_one_sweep", 64'(n_id - id0), 64'd1);
        check_queues("collide_fill");

        // Simultaneous miss and inval in IDLE: sweep first
        push_sweep();
        push_fill();
        do_fill(1'b0, 1'b0, 1'b1, lat2);
        repeat (5) @(posedge nGCLK);
        check_queues("collide_idle");

        // Reset after 3 acked beats
        tag_q.push_back('{sel: LINE, data: TAGINV, fd: 1'b0, id: 1'b0});
        for (int i = 0; i < 3; i++)
            dram_q.push_back('{sel: {LINE, exp_word[i]},
                               data: 32'hC0DE_0000 | {16'h0000, exp_addr[i][15:0]},
                               addr: exp_addr[i]});
        @(posedge nGCLK); #1;
        miss = 1'b1;
        miss_addr = ADDR;
        mem_ack = 1'b1;
        repeat (5) @(posedge nGCLK);
        #2;
        reset = 1'b1;
        #1;
        check_zero("rst_fill");
        check_queues("rst_fill");
        miss = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge nGCLK);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge nGCLK);

        // Reset mid-sweep, away from any clock edge
        @(posedge nGCLK); #1;
        push_sweep();
        inval_req = 1'b1;
        @(posedge nGCLK); #1;
        inval_req = 1'b0;
        repeat (20) @(posedge nGCLK);
        #2;
        chk("sweep_active_before_rst", 64'({busy, tag_wr_ena}), 64'b11);
        reset = 1'b1;
        #1;
        check_zero("rst_sweep");
        tag_q.delete();
        repeat (2) @(posedge nGCLK);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge nGCLK);
        #1;
        chk("idle_after_rst", 64'(busy), 64'd0);
        check_queues("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
